// File: rtl/unix_time_decoder.sv
// Splits a seconds count into day/hour/min/sec with one shared restoring divider
// stepped through /86400, /3600 and /60, one quotient bit per clock.
module unix_time_decoder #(
  parameter int T_WIDTH   = 28,
  parameter int DAY_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [T_WIDTH-1:0]   t,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [DAY_WIDTH-1:0] day,
  output logic [4:0]           hour,
  output logic [5:0]           min,
  output logic [5:0]           sec
);

  localparam int CW = (T_WIDTH > 17) ? $clog2(T_WIDTH) : 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DIV_DAY  = 3'd1,
    S_DIV_HOUR = 3'd2,
    S_DIV_MIN  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [T_WIDTH-1:0]   dividend_q, dividend_d;
  logic [16:0]          rem_q, rem_d;
  logic [T_WIDTH-1:0]   quo_q, quo_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DAY_WIDTH-1:0] day_stg_q, day_stg_d;
  logic [4:0]           hour_stg_q, hour_stg_d;
  logic [5:0]           min_stg_q, min_stg_d;
  logic [5:0]           sec_stg_q, sec_stg_d;
  logic                 busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [DAY_WIDTH-1:0] day_q, day_d;
  logic [4:0]           hour_q, hour_d;
  logic [5:0]           min_q, min_d;
  logic [5:0]           sec_q, sec_d;

  logic [16:0]          divisor_s;
  logic [17:0]          trial_s;
  logic                 qbit_s;
  logic [16:0]          new_rem_s;
  logic [T_WIDTH-1:0]   new_quo_s;
  logic                 last_s;

  // One restoring-division step; trial needs 18 bits since it can reach 2*86400-1.
  always_comb begin
    case (state_q)
      S_DIV_HOUR: divisor_s = 17'd3600;
      S_DIV_MIN:  divisor_s = 17'd60;
      default:    divisor_s = 17'd86400;
    endcase
    trial_s   = {rem_q, dividend_q[cnt_q]};
    qbit_s    = (trial_s >= {1'b0, divisor_s});
    new_rem_s = qbit_s ? 17'(trial_s - {1'b0, divisor_s}) : trial_s[16:0];
    new_quo_s = {quo_q[T_WIDTH-2:0], qbit_s};
    last_s    = (cnt_q == '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start)  state_d = S_DIV_DAY;  else state_d = S_IDLE;
      S_DIV_DAY:  if (last_s) state_d = S_DIV_HOUR; else state_d = S_DIV_DAY;
      S_DIV_HOUR: if (last_s) state_d = S_DIV_MIN;  else state_d = S_DIV_HOUR;
      S_DIV_MIN:  if (last_s) state_d = S_DONE;     else state_d = S_DIV_MIN;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Datapath and output register updates.
  always_comb begin
    dividend_d = dividend_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    day_stg_d  = day_stg_q;
    hour_stg_d = hour_stg_q;
    min_stg_d  = min_stg_q;
    sec_stg_d  = sec_stg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    day_d      = day_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dividend_d = t;
          rem_d      = 17'd0;
          quo_d      = '0;
          cnt_d      = CW'(T_WIDTH - 1);
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      S_DIV_DAY, S_DIV_HOUR, S_DIV_MIN: begin
        rem_d = new_rem_s;
        quo_d = new_quo_s;
        cnt_d = cnt_q - CW'(1);
        if (last_s) begin
          // Each stage's remainder becomes the next stage's dividend.
          rem_d = 17'd0;
          quo_d = '0;
          if (state_q == S_DIV_DAY) begin
            day_stg_d  = new_quo_s[DAY_WIDTH-1:0];
            dividend_d = T_WIDTH'(new_rem_s);
            cnt_d      = CW'(16);
          end else if (state_q == S_DIV_HOUR) begin
            hour_stg_d = new_quo_s[4:0];
            dividend_d = T_WIDTH'(new_rem_s[11:0]);
            cnt_d      = CW'(11);
          end else begin
            min_stg_d  = new_quo_s[5:0];
            sec_stg_d  = new_rem_s[5:0];
          end
        end
      end
      S_DONE: begin
        day_d   = day_stg_q;
        hour_d  = hour_stg_q;
        min_d   = min_stg_q;
        sec_d   = sec_stg_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dividend_q <= '0;
      rem_q      <= 17'd0;
      quo_q      <= '0;
      cnt_q      <= '0;
      day_stg_q  <= '0;
      hour_stg_q <= 5'd0;
      min_stg_q  <= 6'd0;
      sec_stg_q  <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      day_q      <= '0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
    end else begin
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      day_stg_q  <= day_stg_d;
      hour_stg_q <= hour_stg_d;
      min_stg_q  <= min_stg_d;
      sec_stg_q  <= sec_stg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      day_q      <= day_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign day   = day_q;
  assign hour  = hour_q;
  assign min   = min_q;
  assign sec   = sec_q;

endmodule
